mux_scanner: RTL and testbench
==============================

Name: mux_scanner

Overview:
- Sequencing stage wrapped around the existing 4:1 multiplexer.
- Drives the mux select lines s0/s1 through channels 0..3. Waits a settle window on each channel, then samples the mux output o.
- Assembles the four samples into a 4-bit snapshot and flags completion with a one-cycle done pulse.
- Sits between control logic (issues start) and any consumer of the parallel channel snapshot.

Parameters:
SETTLE, 2, cycles each channel is held on s0/s1 before its sample is taken; legal range 1..15.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset; clears all state immediately
start  input  1  request a scan; sampled only in IDLE
o_in  input  1  mux output o (combinational from the mux)
s0  output  1  mux select MSB; channel index bit 1
s1  output  1  mux select LSB; channel index bit 0
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when data has been updated
data  output  4  last completed snapshot; bit k = mux output with channel k selected (0=a, 1=b, 2=c, 3=d)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ch=0, cnt=0, shadow=0, data=0, s0=s1=0, busy=0, done=0. Effective mid-scan; the partial scan is discarded.
- Channel mapping: s0=ch[1], s1=ch[0]. s0/s1 are registered and follow ch directly. In IDLE they rest at 0 (channel a).
- States: IDLE, WAIT.
- IDLE: busy=0. On an edge with start=1: state->WAIT, ch=0, cnt=0, busy=1.
- WAIT, cnt < SETTLE-1: cnt++.
- WAIT, cnt == SETTLE-1, ch < 3: shadow[ch] <= o_in, ch++, cnt=0.
- WAIT, cnt == SETTLE-1, ch == 3:
  - data <= {o_in, shadow[2:0]}
  - done=1 for exactly the following cycle
  - busy=0, ch=0, cnt=0, state->IDLE
- Timing: if start is sampled at edge E0, channel k is sampled at edge E0+(k+1)*SETTLE. data and done change at edge E0+4*SETTLE. Scan latency is 4*SETTLE cycles.
- Each channel is driven on s0/s1 for exactly SETTLE cycles before its sample edge.
- start while busy: ignored, not queued.
- start held high continuously: new scan begins on the edge after done asserts. Scan period = 4*SETTLE+1 cycles.
- data only changes at scan completion. It holds the old value during a scan and after reset until the first completion.
- done is never high while busy=1 and never high for more than one cycle.
- cnt register width: 4 bits, sized for SETTLE max 15.
- SETTLE=1: one cycle per channel; the sample is taken on the edge after the select changes.

Test Plan:
- Reset: hold rst_n=0 with start=1 and a toggling o_in -> s0=s1=busy=done=0, data=4'b0000 throughout.
- Basic scan, SETTLE=2: mux inputs a=1,b=0,c=1,d=1, start pulsed at E0 -> s0s1 = 00,01,10,11 for 2 cycles each; done=1 in the cycle after E0+8; data=4'b1101; busy low again.
- Async reset mid-scan: assert rst_n=0 between edges during channel 2 -> outputs clear without waiting for a clock edge. After release, a fresh scan with a=0,b=1,c=1,d=0 -> data=4'b0110.
- start ignored while busy: pulse start at E0, again at E0+3 -> exactly one done pulse, at E0+8; no second scan follows.
- Back-to-back scans, SETTLE=1, start held high: change inputs to a=b=c=d=0 after the first done -> done pulses every 5 cycles; data goes 4'b1101 then 4'b0000.
- data hold: during a scan with all inputs changed to 0 -> data stays 4'b1101 until the completion edge, then becomes 4'b0000.

Source files
------------

// File: rtl/mux_scanner_if.sv
// Handshake and sample bus between the channel scanner, the 4:1 mux and control logic.
// The slave side is the scanner itself; the master side is the surrounding logic.
interface mux_scanner_if;
    logic       start;
    logic       o_in;
    logic       s0;
    logic       s1;
    logic       busy;
    logic       done;
    logic [3:0] data;

    modport master (
        output start,
        output o_in,
        input  s0,
        input  s1,
        input  busy,
        input  done,
        input  data
    );

    modport slave (
        input  start,
        input  o_in,
        output s0,
        output s1,
        output busy,
        output done,
        output data
    );
endinterface

// File: rtl/mux_scanner.sv
// Steps the 4:1 mux selects through channels 0..3, samples o after SETTLE cycles
// per channel, and publishes the 4-bit snapshot with a one-cycle done pulse.
module mux_scanner #(
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_scanner_if.slave  bus
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state, state_nxt;
    logic [1:0] ch, ch_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [2:0] shadow, shadow_nxt;
    logic [3:0] data, data_nxt;
    logic       busy, busy_nxt;
    logic       done, done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ch     <= 2'd0;
            cnt    <= 4'd0;
            shadow <= 3'd0;
            data   <= 4'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ch     <= ch_nxt;
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
            data   <= data_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ch_nxt     = ch;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        data_nxt   = data;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = WAIT;
                    ch_nxt    = 2'd0;
                    cnt_nxt   = 4'd0;
                    busy_nxt  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt != CNT_LAST) begin
                    cnt_nxt = cnt + 4'd1;
                end else if (ch != 2'd3) begin
                    // Channels 0..2 park in the shadow until the last sample arrives.
                    case (ch)
                        2'd0:    shadow_nxt[0] = bus.o_in;
                        2'd1:    shadow_nxt[1] = bus.o_in;
                        default: shadow_nxt[2] = bus.o_in;
                    endcase
                    ch_nxt  = ch + 2'd1;
                    cnt_nxt = 4'd0;
                end else begin
                    data_nxt  = {bus.o_in, shadow};
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    ch_nxt    = 2'd0;
                    cnt_nxt   = 4'd0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select lines come straight off the channel register, so they rest on channel a in IDLE.
    assign bus.s0   = ch[1];
    assign bus.s1   = ch[0];
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.data = data;

endmodule

// File: tb/tb_mux_scanner.sv
// Bench for mux_scanner: two instances (SETTLE=2 and SETTLE=1) driven by directed and
// random stimulus, compared each cycle against a scan-timeline reference model.
module tb_mux_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] in0;
    logic [3:0] in1;
    int         checks;
    int         errors;

    mux_scanner_if bus0 ();
    mux_scanner_if bus1 ();

    // Each mux is modelled directly: o is the input picked by {s0,s1}.
    assign bus0.o_in = in0[{bus0.s0, bus0.s1}];
    assign bus1.o_in = in1[{bus1.s0, bus1.s1}];

    mux_scanner #(.SETTLE(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mux_scanner #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: cycles elapsed since the accepted start, collected samples, outputs.
    int         settle [2] = '{2, 1};
    bit         m_busy [2];
    int         m_t    [2];
    logic [3:0] m_snap [2];
    logic [3:0] m_data [2];
    bit         m_done [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0;
            m_t[i]    = 0;
            m_snap[i] = 4'd0;
            m_data[i] = 4'd0;
            m_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i, input logic st, input logic [3:0] inp);
        int k;
        m_done[i] = 1'b0;
        if (!m_busy[i]) begin
            if (st) begin
                m_busy[i] = 1'b1;
                m_t[i]    = 0;
            end
        end else begin
            m_t[i] = m_t[i] + 1;
            if (m_t[i] % settle[i] == 0) begin
                k = m_t[i] / settle[i] - 1;
                m_snap[i][k] = inp[k];
            end
            if (m_t[i] == 4 * settle[i]) begin
                m_data[i] = m_snap[i];
                m_done[i] = 1'b1;
                m_busy[i] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string name, input int i, input logic s0, input logic s1,
                           input logic busy, input logic done, input logic [3:0] data);
        logic [1:0] exp_sel;
        exp_sel = m_busy[i] ? 2'(m_t[i] / settle[i]) : 2'd0;
        chk({name, "_sel"},  {2'b00, s0, s1}, {2'b00, exp_sel});
        chk({name, "_busy"}, {3'b000, busy},  {3'b000, m_busy[i]});
        chk({name, "_done"}, {3'b000, done},  {3'b000, m_done[i]});
        chk({name, "_data"}, data,            m_data[i]);
    endtask

    task automatic check_all();
        chk_dut("s2", 0, bus0.s0, bus0.s1, bus0.busy, bus0.done, bus0.data);
        chk_dut("s1", 1, bus1.s0, bus1.s1, bus1.busy, bus1.done, bus1.data);
    endtask

    // One clock: model advances on the edge with the pre-edge inputs, outputs checked at negedge.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) begin
            model_edge(0, bus0.start, in0);
            model_edge(1, bus1.start, in1);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int n;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus0.start = 1'b1;
        bus1.start = 1'b1;
        in0        = 4'hF;
        in1        = 4'hF;
        model_reset();

        // Reset held with start high and inputs toggling: everything stays cleared.
        for (int i = 0; i < 4; i++) begin
            in0 = ~in0;
            in1 = ~in1;
            cyc();
            chk("reset_data", bus0.data, 4'b0000);
        end
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        rst_n      = 1'b1;

        // Basic scan at SETTLE=2: a=1 b=0 c=1 d=1.
        in0 = 4'b1101;
        bus0.start = 1'b1;
        cyc();
        bus0.start = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        chk("basic_done", {3'b000, bus0.done}, 4'b0001);
        chk("basic_data", bus0.data, 4'b1101);
        cyc();
        chk("basic_idle", {2'b00, bus0.busy, bus0.done}, 4'b0000);

        // Asynchronous reset while channel 2 is selected.
        in0 = 4'b0000;
        bus0.start = 1'b1;
        cyc();
        bus0.start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_outs", {bus0.s0, bus0.s1, bus0.busy, bus0.done}, 4'b0000);
        chk("async_rst_data", bus0.data, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        in0 = 4'b0110;
        bus0.start = 1'b1;
        cyc();
        bus0.start = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        chk("post_rst_data", bus0.data, 4'b0110);

        // A second start while busy is dropped: one done only.
        in0 = 4'b1101;
        n = 0;
        bus0.start = 1'b1;
        cyc();
        bus0.start = 1'b0;
        cyc();
        cyc();
        bus0.start = 1'b1;
        cyc();
        bus0.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (bus0.done) n++;
        end
        chk("ignored_start_dones", 4'(n), 4'd1);
        chk("ignored_start_data", bus0.data, 4'b1101);

        // Data hold: inputs drop to zero for the next scan, old snapshot visible until completion.
        in0 = 4'b0000;
        bus0.start = 1'b1;
        cyc();
        bus0.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("hold_data", bus0.data, 4'b1101);
        end
        cyc();
        chk("hold_new_data", bus0.data, 4'b0000);
        cyc();

        // Back-to-back at SETTLE=1 with start held high.
        in1 = 4'b1101;
        bus1.start = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n == 0; i++) begin
            cyc();
            if (bus1.done) n = 1;
        end
        chk("b2b_first_seen", 4'(n), 4'd1);
        chk("b2b_first_data", bus1.data, 4'b1101);
        in1 = 4'b0000;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus1.done) n++;
        end
        chk("b2b_dones_in_10", 4'(n), 4'd2);
        chk("b2b_second_data", bus1.data, 4'b0000);
        bus1.start = 1'b0;
        for (int i = 0; i < 6; i++) cyc();

        // Random start pulses and input changes, including changes mid-scan.
        for (int i = 0; i < 600; i++) begin
            bus0.start = ($urandom_range(0, 3) == 0);
            bus1.start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) in0 = 4'($urandom);
            if ($urandom_range(0, 2) == 0) in1 = 4'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
